// File: rtl/quiz_pkg.sv
// Shared types and constants for the quiz round sequencer.
// Covers the state encoding, operator and digit-select codes, datapath widths and the operand clamp.
package quiz_pkg;

    localparam int OPND_W = 4;
    localparam int RES_W  = 7;
    localparam int CNT_W  = 8;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SHOW_A = 3'd2,
        S_SHOW_B = 3'd3,
        S_SHOW_R = 3'd4,
        S_ANSWER = 3'd5,
        S_SCORE  = 3'd6,
        S_OVER   = 3'd7
    } state_t;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;

    localparam logic [1:0] SEL_BLANK = 2'd0;
    localparam logic [1:0] SEL_A     = 2'd1;
    localparam logic [1:0] SEL_B     = 2'd2;
    localparam logic [1:0] SEL_RES   = 2'd3;

    // Random sources span 0..15, but the display only shows single decimal digits.
    function automatic logic [OPND_W-1:0] clamp9(input logic [OPND_W-1:0] v);
        return (v > 4'd9) ? 4'd9 : v;
    endfunction

endpackage

// File: rtl/quiz_phase_timer.sv
// Counts divider ticks within one phase.
// done is high in the cycle that carries the target-th tick, so the phase leaves on that edge.
module quiz_phase_timer
    import quiz_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             tick,
    input  logic [CNT_W-1:0] target,
    output logic             done
);

    logic [CNT_W-1:0] count_reg;

    assign done = tick && (count_reg >= target - CNT_W'(1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count_reg <= '0;
        end else if (tick) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

endmodule

// File: rtl/quiz_round_ctrl.sv
// Round sequencer for the arithmetic quiz: load operands, show A/B/result, run the answer window, then score.
// Build option: define QUIZ_PENALTY_EN to subtract a point on a wrong or timed-out answer.
module quiz_round_ctrl
    import quiz_pkg::*;
#(
    parameter int SHOW_TICKS   = 3,
    parameter int ANSWER_TICKS = 8,
    parameter int MAX_POINTS   = 9,
    parameter int ROUNDS       = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             start,
    input  logic [3:0]       rand_a,
    input  logic [3:0]       rand_b,
    input  logic [3:0]       switch,
    output logic [1:0]       num_sel,
    output logic [RES_W-1:0] disp_val,
    output logic [1:0]       operator,
    output logic [3:0]       point,
    output logic             game_over,
    output logic             busy,
    output logic             correct,
    output logic             round_done
);

`ifdef QUIZ_PENALTY_EN
    localparam bit PENALTY_EN = 1'b1;
`else
    localparam bit PENALTY_EN = 1'b0;
`endif

    localparam logic [CNT_W-1:0] SHOW_T   = CNT_W'(SHOW_TICKS);
    localparam logic [CNT_W-1:0] ANSWER_T = CNT_W'(ANSWER_TICKS);
    localparam logic [3:0]       MAX_P    = 4'(MAX_POINTS);
    localparam logic [3:0]       ROUNDS_C = 4'(ROUNDS);

    state_t              state_reg;
    logic [OPND_W-1:0]   op_b_reg;
    logic [RES_W-1:0]    result_reg;
    logic [3:0]          sw_prev_reg;
    logic [3:0]          round_cnt_reg;

    logic [3:0]          rise;
    logic [OPND_W-1:0]   a_cl, b_cl, ld_a, ld_b;
    logic [1:0]          ld_op;
    logic [RES_W-1:0]    ld_res;
    logic                timed, timer_clear, timer_done;
    logic                ans_hit, ans_ok;
    logic [CNT_W-1:0]    timer_target;

    for (genvar gi = 0; gi < 4; gi++) begin : g_rise
        assign rise[gi] = switch[gi] & ~sw_prev_reg[gi];
    end

    always_comb begin
        a_cl = clamp9(rand_a);
        b_cl = clamp9(rand_b);
        ld_a = (a_cl >= b_cl) ? a_cl : b_cl;
        ld_b = (a_cl >= b_cl) ? b_cl : a_cl;
        if (ld_a <= 4'd3) begin
            ld_op = OP_ADD;
        end else if (ld_a <= 4'd7) begin
            ld_op = OP_SUB;
        end else begin
            ld_op = OP_MUL;
        end
        case (ld_op)
            OP_ADD:  ld_res = {3'b000, ld_a} + {3'b000, ld_b};
            OP_SUB:  ld_res = {3'b000, ld_a} - {3'b000, ld_b};
            default: ld_res = {3'b000, ld_a} * {3'b000, ld_b};
        endcase
    end

    assign ans_hit = (state_reg == S_ANSWER) && (rise != 4'd0);
    assign ans_ok  = (rise == (4'd1 << operator));

    // The counter restarts whenever it is outside a timed phase or the phase is ending,
    // so each phase starts from zero.
    assign timed = (state_reg == S_SHOW_A) || (state_reg == S_SHOW_B) ||
                   (state_reg == S_SHOW_R) || (state_reg == S_ANSWER);
    assign timer_clear  = !timed || timer_done || ans_hit;
    assign timer_target = (state_reg == S_ANSWER) ? ANSWER_T : SHOW_T;

    quiz_phase_timer u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (timer_clear),
        .tick   (tick),
        .target (timer_target),
        .done   (timer_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            op_b_reg      <= '0;
            result_reg    <= '0;
            sw_prev_reg   <= '0;
            round_cnt_reg <= '0;
            num_sel       <= SEL_BLANK;
            disp_val      <= '0;
            operator      <= OP_ADD;
            point         <= '0;
            game_over     <= 1'b0;
            busy          <= 1'b0;
            correct       <= 1'b0;
            round_done    <= 1'b0;
        end else begin
            sw_prev_reg <= switch;
            correct     <= 1'b0;
            round_done  <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        state_reg <= S_LOAD;
                        busy      <= 1'b1;
                    end
                end
                S_OVER: begin
                    if (start) begin
                        state_reg     <= S_LOAD;
                        busy          <= 1'b1;
                        game_over     <= 1'b0;
                        point         <= '0;
                        round_cnt_reg <= '0;
                    end
                end
                S_LOAD: begin
                    op_b_reg   <= ld_b;
                    result_reg <= ld_res;
                    operator   <= ld_op;
                    num_sel    <= SEL_A;
                    disp_val   <= {3'b000, ld_a};
                    state_reg  <= S_SHOW_A;
                end
                S_SHOW_A: begin
                    if (timer_done) begin
                        state_reg <= S_SHOW_B;
                        num_sel   <= SEL_B;
                        disp_val  <= {3'b000, op_b_reg};
                    end
                end
                S_SHOW_B: begin
                    if (timer_done) begin
                        state_reg <= S_SHOW_R;
                        num_sel   <= SEL_RES;
                        disp_val  <= result_reg;
                    end
                end
                S_SHOW_R: begin
                    if (timer_done) begin
                        state_reg <= S_ANSWER;
                        num_sel   <= SEL_BLANK;
                        disp_val  <= '0;
                    end
                end
                S_ANSWER: begin
                    // A press in the same cycle as the final tick still counts as an answer.
                    if (ans_hit || timer_done) begin
                        state_reg     <= S_SCORE;
                        round_done    <= 1'b1;
                        correct       <= ans_hit && ans_ok;
                        round_cnt_reg <= round_cnt_reg + 4'd1;
                        if (ans_hit && ans_ok) begin
                            if (point < MAX_P) begin
                                point <= point + 4'd1;
                            end
                        end else if (PENALTY_EN && (point != 4'd0)) begin
                            point <= point - 4'd1;
                        end
                    end
                end
                S_SCORE: begin
                    if ((point == MAX_P) || (round_cnt_reg == ROUNDS_C)) begin
                        state_reg <= S_OVER;
                        game_over <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        state_reg <= S_LOAD;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_quiz_round_ctrl.sv
// Bench for quiz_round_ctrl: a procedural game-timeline model checked against the DUT every cycle,
// plus hand-computed spot checks taken from directed rounds.
module tb_quiz_round_ctrl;

    localparam int SHOW = 3;
    localparam int ANS  = 8;
    localparam int MAXP = 2;
    localparam int RNDS = 4;
`ifdef QUIZ_PENALTY_EN
    localparam bit PEN = 1'b1;
`else
    localparam bit PEN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset, tick, start;
    logic [3:0] rand_a, rand_b, switch;
    logic [1:0] num_sel;
    logic [6:0] disp_val;
    logic [1:0] operator;
    logic [3:0] point;
    logic       game_over, busy, correct, round_done;

    quiz_round_ctrl #(
        .SHOW_TICKS   (SHOW),
        .ANSWER_TICKS (ANS),
        .MAX_POINTS   (MAXP),
        .ROUNDS       (RNDS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .start      (start),
        .rand_a     (rand_a),
        .rand_b     (rand_b),
        .switch     (switch),
        .num_sel    (num_sel),
        .disp_val   (disp_val),
        .operator   (operator),
        .point      (point),
        .game_over  (game_over),
        .busy       (busy),
        .correct    (correct),
        .round_done (round_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Divider strobe: one tick every tick_div cycles.
    int cyc = 0;
    int tick_div = 3;
    initial begin
        tick = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            tick = ((cyc % tick_div) == 0);
        end
    end

    // ---------------- model: game timeline ----------------
    int  exp_sel, exp_disp, exp_op, exp_point, exp_go, exp_busy, exp_correct, exp_rd;
    int  m_ph;          // 0 idle,1 load,2 A,3 B,4 R,5 answer,6 score,7 over
    int  pts, rnd;
    bit  aborted;
    bit  tick_s;
    logic [3:0] sw_last, rise_s;

    task automatic model_reset_vals();
        exp_sel = 0; exp_disp = 0; exp_op = 0; exp_point = 0;
        exp_go = 0; exp_busy = 0; exp_correct = 0; exp_rd = 0;
        m_ph = 0;
    endtask

    task automatic edge_();
        @(posedge clk);
        tick_s  = tick;
        rise_s  = switch & ~sw_last;
        sw_last = switch;
        if (reset) begin
            aborted = 1'b1;
            sw_last = 4'd0;
            model_reset_vals();
        end
    endtask

    task automatic play_game();
        int a, b, t, op, res, n;
        bit ok, done;
        pts = 0; rnd = 0;
        exp_busy = 1; exp_go = 0; exp_point = 0; m_ph = 1;
        forever begin
            edge_(); if (aborted) return;
            a = (rand_a > 9) ? 9 : int'(rand_a);
            b = (rand_b > 9) ? 9 : int'(rand_b);
            if (a < b) begin t = a; a = b; b = t; end
            op  = (a <= 3) ? 0 : (a <= 7) ? 1 : 2;
            res = (op == 0) ? a + b : (op == 1) ? a - b : a * b;
            exp_op = op; exp_sel = 1; exp_disp = a; m_ph = 2;
            for (int ph = 0; ph < 3; ph++) begin
                n = 0;
                while (n < SHOW) begin
                    edge_(); if (aborted) return;
                    if (tick_s) n++;
                end
                case (ph)
                    0: begin exp_sel = 2; exp_disp = b;   m_ph = 3; end
                    1: begin exp_sel = 3; exp_disp = res; m_ph = 4; end
                    default: begin exp_sel = 0; exp_disp = 0; m_ph = 5; end
                endcase
            end
            n = 0; done = 1'b0; ok = 1'b0;
            while (!done) begin
                edge_(); if (aborted) return;
                if (rise_s != 4'd0) begin
                    ok = (rise_s == (4'd1 << op)); done = 1'b1;
                end else if (tick_s) begin
                    n++;
                    if (n == ANS) done = 1'b1;
                end
            end
            rnd++;
            if (ok) pts = (pts < MAXP) ? pts + 1 : pts;
            else if (PEN && pts > 0) pts = pts - 1;
            exp_point = pts; exp_correct = ok; exp_rd = 1; m_ph = 6;
            edge_(); if (aborted) return;
            exp_correct = 0; exp_rd = 0;
            if (pts == MAXP || rnd == RNDS) begin
                exp_go = 1; exp_busy = 0; m_ph = 7;
                return;
            end
            m_ph = 1;
        end
    endtask

    initial begin : model
        model_reset_vals();
        sw_last = 4'd0; aborted = 1'b0;
        forever begin
            edge_();
            if (aborted) begin
                aborted = 1'b0;
            end else if (start) begin
                play_game();
                aborted = 1'b0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin : compare
        forever begin
            @(posedge clk);
            #1;
            chk("num_sel",    int'(num_sel),    exp_sel);
            chk("disp_val",   int'(disp_val),   exp_disp);
            chk("operator",   int'(operator),   exp_op);
            chk("point",      int'(point),      exp_point);
            chk("game_over",  int'(game_over),  exp_go);
            chk("busy",       int'(busy),       exp_busy);
            chk("correct",    int'(correct),    exp_correct);
            chk("round_done", int'(round_done), exp_rd);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic wait_ph(input int ph, input int budget);
        for (int k = 0; k < budget && m_ph != ph; k++) @(negedge clk);
        if (m_ph != ph) chk("wait_phase", m_ph, ph);
    endtask

    task automatic press(input logic [3:0] v);
        switch = v;
        $display("txn press switch=%b a=%0d b=%0d", v, rand_a, rand_b);
        @(negedge clk);
    endtask

    initial begin : stim
        reset = 1'b1; start = 1'b0; switch = 4'd0; rand_a = 4'd0; rand_b = 4'd0;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_num_sel", int'(num_sel), 0);
        chk("rst_point", int'(point), 0);
        reset = 1'b0;

        // Game 1, round 1: 2,5 -> sub, 5/2/3
        rand_a = 4'd2; rand_b = 4'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("load_busy", int'(busy), 1);
        wait_ph(2, 10);  chk("g1r1_A", int'(disp_val), 5); chk("g1r1_op", int'(operator), 1);
        wait_ph(3, 20);  chk("g1r1_B", int'(disp_val), 2);
        wait_ph(4, 20);  chk("g1r1_R", int'(disp_val), 3); chk("g1r1_sel", int'(num_sel), 3);
        wait_ph(5, 20);
        press(4'b0010);
        chk("g1r1_correct", int'(correct), 1); chk("g1r1_point", int'(point), 1);
        switch = 4'd0; tick_div = 1;
        rand_a = 4'd14; rand_b = 4'd1;

        // Round 2: 14,1 -> clamp 9, mul, 9; switch[2] held into ANSWER
        wait_ph(2, 10);  chk("g1r2_A", int'(disp_val), 9);
        switch = 4'b0100;
        wait_ph(4, 20);  chk("g1r2_R", int'(disp_val), 9); chk("g1r2_op", int'(operator), 2);
        wait_ph(5, 20);
        repeat (3) @(negedge clk);
        chk("g1r2_held_rd", int'(round_done), 0);
        switch = 4'd0;
        @(negedge clk);
        press(4'b0100);
        chk("g1r2_correct", int'(correct), 1); chk("g1r2_point", int'(point), 2);
        switch = 4'd0;
        start = 1'b1;                       // held through OVER: restarts once
        rand_a = 4'd9; rand_b = 4'd8;
        wait_ph(7, 5);
        chk("g1_over", int'(game_over), 1); chk("g1_busy", int'(busy), 0);

        // Game 2, round 1: 9,8 -> mul 72, wrong press
        wait_ph(2, 10);
        start = 1'b0;
        wait_ph(4, 20);  chk("g2r1_R", int'(disp_val), 72); chk("g2r1_op", int'(operator), 2);
        wait_ph(5, 20);
        press(4'b0001);
        chk("g2r1_rd", int'(round_done), 1); chk("g2r1_correct", int'(correct), 0);
        chk("g2r1_point", int'(point), 0);
        switch = 4'd0;
        rand_a = 4'd3; rand_b = 4'd0;

        // Round 2: 3,0 -> add, timeout
        wait_ph(2, 10);  chk("g2r2_A", int'(disp_val), 3); chk("g2r2_op", int'(operator), 0);
        wait_ph(6, 40);
        chk("g2r2_rd", int'(round_done), 1); chk("g2r2_correct", int'(correct), 0);
        rand_a = 4'd7; rand_b = 4'd7;

        // Round 3: 7,7 -> sub 0, press on the final timeout tick
        wait_ph(4, 20);  chk("g2r3_R", int'(disp_val), 0); chk("g2r3_op", int'(operator), 1);
        wait_ph(5, 20);
        repeat (ANS - 1) @(negedge clk);
        press(4'b0010);
        chk("g2r3_correct", int'(correct), 1); chk("g2r3_point", int'(point), 1);
        switch = 4'd0;
        rand_a = 4'd1; rand_b = 4'd1;

        // Round 4: 1,1 -> add, two rises together
        wait_ph(5, 40);
        press(4'b0011);
        chk("g2r4_rd", int'(round_done), 1); chk("g2r4_correct", int'(correct), 0);
        switch = 4'd0;
        wait_ph(7, 5);
        chk("g2_over", int'(game_over), 1); chk("g2_point", int'(point), PEN ? 0 : 1);

        // Game 3: reset in SHOW_B
        rand_a = 4'd4; rand_b = 4'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_ph(3, 20);
        chk("g3_sel", int'(num_sel), 2);
        reset = 1'b1;
        @(negedge clk);
        chk("g3_rst_sel", int'(num_sel), 0); chk("g3_rst_disp", int'(disp_val), 0);
        chk("g3_rst_op", int'(operator), 0); chk("g3_rst_busy", int'(busy), 0);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("g3_idle_busy", int'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
